mem_port_arbiter: RTL and testbench

- Shares the single DRAM master-FIFO request/response port between two cache-side requesters: requester 0 is the instruction L1, requester 1 is the data L1.
- Sits between the L1 cache instances and the FIFO adapter in the memory subsystem top.
- Serialises traffic with at most one outstanding transaction and round-robin fairness.
- Routes the read line back to the owner and acknowledges writes.

---
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one DRAM FIFO port between the instruction and data L1s
module mem_port_arbiter #(
  parameter int ADDR_W         = 27,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              sys_clk,
  input  logic              RST,
  input  logic              r0_valid,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [LINE_W-1:0] r0_data,
  output logic              r0_ready,
  output logic [LINE_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [LINE_W-1:0] r1_data,
  output logic              r1_ready,
  output logic [LINE_W-1:0] r1_rdata,
  output logic              mem_req_en,
  output logic              mem_req_cmd,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_req_rdy,
  input  logic              mem_rsp_en,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic last_grant, gnt;
  always_comb begin
    state_n = state;
    gnt = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
    case (state)
      IDLE:     state_n = (r0_valid || r1_valid) ? ISSUE : IDLE;
      ISSUE:    state_n = !mem_req_rdy ? ISSUE : mem_req_cmd ? WAIT_RSP : DONE;
      WAIT_RSP: state_n = mem_rsp_en ? DONE : WAIT_RSP;
      DONE:     state_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every port comes straight from a flop
  always_ff @(posedge sys_clk) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      r0_ready     <= 1'b0;
      r1_ready     <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      mem_req_en   <= 1'b0;
      mem_req_cmd  <= 1'b0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
    end else begin
      state      <= state_n;
      busy       <= state_n != IDLE;
      mem_req_en <= state_n == ISSUE;
      r0_ready   <= state_n == DONE && !owner;
      r1_ready   <= state_n == DONE && owner;
      if (state == IDLE && (r0_valid || r1_valid)) begin
        owner        <= gnt;
        mem_req_cmd  <= gnt ? !r1_rw : !r0_rw;
        mem_req_addr <= gnt ? r1_addr : r0_addr;
        mem_req_data <= gnt ? r1_data : r0_data;
      end
      if (state == ISSUE && mem_req_rdy) cnt <= '0;
      if (state == WAIT_RSP && mem_rsp_en) begin
        if (owner) r1_rdata <= mem_rsp_data;
        else r0_rdata <= mem_rsp_data;
      end else if (state == WAIT_RSP) begin
        if (cnt == CW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
      if (state == DONE) last_grant <= owner;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic against a transaction-level arbiter model
module tb_mem_port_arbiter;
  localparam int AW = 27;
  localparam int LW = 128;
  localparam int TO = 16;
  logic sys_clk = 1'b0;
  logic RST = 1'b1;
  logic r0_valid, r0_rw, r0_ready, r1_valid, r1_rw, r1_ready;
  logic [AW-1:0] r0_addr, r1_addr, mem_req_addr;
  logic [LW-1:0] r0_data, r1_data, r0_rdata, r1_rdata, mem_req_data, mem_rsp_data;
  logic mem_req_en, mem_req_cmd, mem_req_rdy, mem_rsp_en, busy, owner, timeout_err;
  logic v [2];
  logic rw [2];
  logic [AW-1:0] ad [2];
  logic [LW-1:0] dt [2];
  int total = 0, bad = 0, cyc = 0;
  bit act, hs, tmo;
  int own = 0, last = 1, d = 0, rsp_at = -1, wcnt = 0;
  logic p_rw;
  logic [AW-1:0] p_addr;
  logic [LW-1:0] p_data;
  logic [LW-1:0] exp_rd [2];
  int req_pct = 0, wr_pct = 50, rdy_pct = 100, stray_pct = 0, rsp_dly = 0;
  bit auto_rq [2];
  bit kick_rsp = 1'b0;
  logic [LW-1:0] rsp_word = '0;
  int en_cnt = 0, rdy_cyc = 0, t0 = 0;
  int rdy_q [$];

  always #5 sys_clk = ~sys_clk;

  assign r0_valid = v[0];
  assign r0_rw    = rw[0];
  assign r0_addr  = ad[0];
  assign r0_data  = dt[0];
  assign r1_valid = v[1];
  assign r1_rw    = rw[1];
  assign r1_addr  = ad[1];
  assign r1_data  = dt[1];

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .RST(RST),
    .r0_valid(r0_valid), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_data(r0_data),
    .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_data(r1_data),
    .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .mem_req_en(mem_req_en), .mem_req_cmd(mem_req_cmd), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_rdy(mem_req_rdy),
    .mem_rsp_en(mem_rsp_en), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  function automatic logic [LW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic new_req(input int i);
    v[i]  = 1'b1;
    rw[i] = int'($urandom_range(99)) < wr_pct;
    ad[i] = AW'($urandom());
    dt[i] = rnd();
  endtask

  // requesters, FIFO backpressure and the memory's response timing for the current cycle
  task automatic drive();
    bit waiting;
    for (int i = 0; i < 2; i++) begin
      if (act && d == cyc && own == i) begin
        v[i] = 1'b0;
        if (auto_rq[i]) new_req(i);
      end else if (!v[i] && int'($urandom_range(99)) < req_pct) new_req(i);
    end
    waiting = act && hs && d == 0 && !p_rw;
    mem_req_rdy = int'($urandom_range(99)) < rdy_pct;
    mem_rsp_en = waiting ? (cyc == rsp_at) : (int'($urandom_range(99)) < stray_pct);
    if (kick_rsp) begin
      mem_rsp_en = 1'b1;
      kick_rsp = 1'b0;
    end
    mem_rsp_data = (rsp_word != '0) ? rsp_word : rnd();
  endtask

  // what the next edge does to the transaction in flight, in terms of grant/handshake/response/done cycles
  task automatic update();
    if (act && d == cyc) begin
      act = 1'b0;
      last = own;
    end else if (!act) begin
      if (v[0] || v[1]) begin
        own = (v[0] && v[1]) ? 1 - last : (v[1] ? 1 : 0);
        p_rw = rw[own];
        p_addr = ad[own];
        p_data = dt[own];
        act = 1'b1;
        hs = 1'b0;
        d = 0;
      end
    end else if (!hs) begin
      if (mem_req_rdy) begin
        hs = 1'b1;
        if (p_rw) d = cyc + 1;
        else begin
          wcnt = 0;
          rsp_at = rsp_dly < 0 ? -1 : cyc + (rsp_dly > 0 ? rsp_dly : int'($urandom_range(8, 1)));
        end
      end
    end else if (d == 0) begin
      if (mem_rsp_en) begin
        d = cyc + 1;
        exp_rd[own] = mem_rsp_data;
      end else begin
        wcnt++;
        if (wcnt >= TO) tmo = 1'b1;
      end
    end
  endtask

  task automatic check(input bit after_rst);
    bit dn;
    dn = act && d == cyc;
    chk("busy", busy, act);
    chk("req_en", mem_req_en, act && !hs);
    if (act && !hs) begin
      chk("req_cmd", mem_req_cmd, !p_rw);
      chk("req_addr", mem_req_addr, p_addr);
      chk("req_data", mem_req_data, p_data);
    end
    chk("r0_ready", r0_ready, dn && own == 0);
    chk("r1_ready", r1_ready, dn && own == 1);
    chk("r0_rdata", r0_rdata, exp_rd[0]);
    chk("r1_rdata", r1_rdata, exp_rd[1]);
    chk("owner", owner, own);
    chk("timeout_err", timeout_err, tmo);
    if (after_rst) begin
      chk("rst_req_cmd", mem_req_cmd, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_req_data", mem_req_data, 0);
    end
    if (mem_req_en) en_cnt++;
    if (r0_ready) rdy_q.push_back(0);
    if (r1_ready) rdy_q.push_back(1);
    if (r0_ready || r1_ready) rdy_cyc = cyc;
  endtask

  task automatic tick();
    bit rst_now;
    drive();
    update();
    @(posedge sys_clk);
    #1;
    cyc++;
    rst_now = RST;
    if (rst_now) begin
      act = 1'b0;
      hs = 1'b0;
      d = 0;
      own = 0;
      last = 1;
      tmo = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      RST = 1'b0;
    end
    check(rst_now);
  endtask

  task automatic drain();
    rdy_pct = 100;
    for (int k = 0; k < 200 && (act || v[0] || v[1]); k++) tick();
    tick();
    chk("drained", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0;
      rw[i] = 1'b0;
      ad[i] = '0;
      dt[i] = '0;
      auto_rq[i] = 1'b0;
      exp_rd[i] = '0;
    end
    mem_req_rdy = 1'b0;
    mem_rsp_en = 1'b0;
    mem_rsp_data = '0;
    tick();
    repeat (2) tick();

    // single read from the instruction side
    v[0] = 1'b1; rw[0] = 1'b0; ad[0] = 27'h0000100; dt[0] = rnd();
    rsp_dly = 5;
    rsp_word = {4{32'h33333333}};
    en_cnt = 0;
    rdy_q.delete();
    repeat (12) tick();
    chk("rd_req_pulses", en_cnt, 1);
    chk("rd_ready_count", rdy_q.size(), 1);
    chk("rd_rdata", r0_rdata, {4{32'h33333333}});
    rsp_word = '0;

    // write acknowledge from the data side
    v[1] = 1'b1; rw[1] = 1'b1; ad[1] = 27'h0000200; dt[1] = {16{8'h0F}};
    t0 = cyc;
    rdy_cyc = -100;
    repeat (6) tick();
    chk("wr_latency", rdy_cyc - t0, 2);

    // both L1s reading back-to-back
    wr_pct = 0;
    rsp_dly = 0;
    auto_rq[0] = 1'b1;
    auto_rq[1] = 1'b1;
    new_req(0);
    new_req(1);
    rdy_q.delete();
    for (int k = 0; k < 200 && rdy_q.size() < 8; k++) tick();
    auto_rq[0] = 1'b0;
    auto_rq[1] = 1'b0;
    chk("fair_count", rdy_q.size(), 8);
    for (int k = 0; k < 8 && k < rdy_q.size(); k++) chk("fair_order", rdy_q[k], k % 2);
    drain();

    // FIFO backpressure with a second requester arriving mid-transaction
    rdy_q.delete();
    en_cnt = 0;
    rdy_pct = 0;
    rsp_dly = 3;
    v[0] = 1'b1; rw[0] = 1'b1; ad[0] = AW'($urandom()); dt[0] = rnd();
    tick();
    v[1] = 1'b1; rw[1] = 1'b0; ad[1] = AW'($urandom()); dt[1] = rnd();
    repeat (10) tick();
    rdy_pct = 100;
    tick();
    chk("bp_en_cycles", en_cnt, 11);
    repeat (20) tick();
    chk("bp_served", rdy_q.size(), 2);
    if (rdy_q.size() >= 2) begin
      chk("bp_first", rdy_q[0], 0);
      chk("bp_second", rdy_q[1], 1);
    end

    // random mixed traffic with backpressure and stray responses
    rsp_dly = 0;
    wr_pct = 50;
    req_pct = 30;
    rdy_pct = 60;
    stray_pct = 20;
    repeat (800) tick();
    req_pct = 0;
    stray_pct = 0;
    drain();

    // response never arrives, then arrives late
    rsp_dly = -1;
    v[0] = 1'b1; rw[0] = 1'b0; ad[0] = AW'($urandom()); dt[0] = rnd();
    repeat (12) tick();
    chk("tmo_early", timeout_err, 0);
    repeat (10) tick();
    chk("tmo_set", timeout_err, 1);
    chk("tmo_still_busy", busy, 1);
    rsp_word = rnd();
    rsp_at = cyc;
    rdy_q.delete();
    repeat (4) tick();
    chk("late_rsp_ready", rdy_q.size(), 1);
    chk("late_rsp_rdata", r0_rdata, rsp_word);
    chk("tmo_sticky", timeout_err, 1);
    rsp_word = '0;

    // reset in the middle of a read, then a stray response
    v[0] = 1'b1; rw[0] = 1'b0; ad[0] = AW'($urandom()); dt[0] = rnd();
    repeat (5) tick();
    chk("pre_rst_busy", busy, 1);
    v[0] = 1'b0;
    rdy_q.delete();
    RST = 1'b1;
    tick();
    tick();
    kick_rsp = 1'b1;
    repeat (4) tick();
    chk("rst_no_ready", rdy_q.size(), 0);
    chk("rst_tmo_clear", timeout_err, 0);
    rsp_dly = 2;
    v[0] = 1'b1; rw[0] = 1'b0; ad[0] = AW'($urandom()); dt[0] = rnd();
    v[1] = 1'b1; rw[1] = 1'b1; ad[1] = AW'($urandom()); dt[1] = rnd();
    repeat (20) tick();
    chk("post_rst_count", rdy_q.size(), 2);
    if (rdy_q.size() >= 2) begin
      chk("post_rst_first", rdy_q[0], 0);
      chk("post_rst_second", rdy_q[1], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
